// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - execute-stage operand/result bundle between ID/EX and EX/MEM
interface ex_muldiv_if #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
);
  logic [2:0]       alu_sel;
  logic [7:0]       alu_op;
  logic [WIDTH-1:0] src_data1;
  logic [WIDTH-1:0] src_data2;
  logic [RADDR-1:0] wr_addr;
  logic             wr_en;
  logic             annul;
  logic [WIDTH-1:0] hi_in;
  logic [WIDTH-1:0] lo_in;
  logic             mem_hilo_wr_en;
  logic [WIDTH-1:0] mem_hi;
  logic [WIDTH-1:0] mem_lo;
  logic             wb_hilo_wr_en;
  logic [WIDTH-1:0] wb_hi;
  logic [WIDTH-1:0] wb_lo;
  logic [RADDR-1:0] out_addr;
  logic [WIDTH-1:0] out_data;
  logic             out_en;
  logic             hilo_wr_en;
  logic [WIDTH-1:0] hi_data;
  logic [WIDTH-1:0] lo_data;
  logic             stall_req;

  modport master (
    output alu_sel, alu_op, src_data1, src_data2, wr_addr, wr_en, annul,
           hi_in, lo_in, mem_hilo_wr_en, mem_hi, mem_lo, wb_hilo_wr_en, wb_hi, wb_lo,
    input  out_addr, out_data, out_en, hilo_wr_en, hi_data, lo_data, stall_req
  );

  modport slave (
    input  alu_sel, alu_op, src_data1, src_data2, wr_addr, wr_en, annul,
           hi_in, lo_in, mem_hilo_wr_en, mem_hi, mem_lo, wb_hilo_wr_en, wb_hi, wb_lo,
    output out_addr, out_data, out_en, hilo_wr_en, hi_data, lo_data, stall_req
  );
endinterface

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - execute stage with logic/shift/move/arith, multiply and iterative divide
module ex_muldiv #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic        clk,
  input  logic        reset,
  ex_muldiv_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH) + 1;

  localparam logic [2:0] SEL_LOGIC = 3'b001, SEL_SHIFT = 3'b010, SEL_MOVE = 3'b011, SEL_ARITH = 3'b100;

  localparam logic [7:0] OP_AND = 8'h24, OP_OR = 8'h25, OP_XOR = 8'h26, OP_NOR = 8'h27;
  localparam logic [7:0] OP_SRL = 8'h02, OP_SRA = 8'h03, OP_SLL = 8'h7C;
  localparam logic [7:0] OP_MOVZ = 8'h0A, OP_MOVN = 8'h0B, OP_MFHI = 8'h10, OP_MTHI = 8'h11;
  localparam logic [7:0] OP_MFLO = 8'h12, OP_MTLO = 8'h13;
  localparam logic [7:0] OP_ADD = 8'h20, OP_ADDU = 8'h21, OP_SUB = 8'h22, OP_SUBU = 8'h23;
  localparam logic [7:0] OP_SLT = 8'h2A, OP_SLTU = 8'h2B;
  localparam logic [7:0] OP_MULT = 8'h18, OP_MULTU = 8'h19, OP_DIV = 8'h1A, OP_DIVU = 8'h1B;

  localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2;

  logic [WIDTH-1:0]   a, b, eff_hi, eff_lo, sum, diff;
  logic               add_ov, sub_ov;
  logic [SHW-1:0]     shamt;
  logic [2*WIDTH-1:0] prod_s, prod_u;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   dvd, dvs, rem, res_q, res_r;
  logic               neg_q, neg_r;
  logic [WIDTH:0]     rem_sh, rem_sub;
  logic               ge;
  logic [WIDTH-1:0]   rem_nx, q_nx, q_fix, r_fix, abs_a, abs_b;
  logic               is_div, div_signed, accept;

  assign a     = bus.src_data1;
  assign b     = bus.src_data2;
  assign shamt = a[SHW-1:0];

  // Forwarded HI/LO: youngest writer (MEM) wins over WB, then the architectural copy
  always_comb begin
    eff_hi = bus.hi_in;
    eff_lo = bus.lo_in;
    if (bus.mem_hilo_wr_en) begin
      eff_hi = bus.mem_hi;
      eff_lo = bus.mem_lo;
    end else if (bus.wb_hilo_wr_en) begin
      eff_hi = bus.wb_hi;
      eff_lo = bus.wb_lo;
    end
  end

  assign sum    = a + b;
  assign diff   = a - b;
  assign add_ov = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ov = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign is_div     = (bus.alu_op == OP_DIV) || (bus.alu_op == OP_DIVU);
  assign div_signed = (bus.alu_op == OP_DIV);
  assign accept     = (state == S_IDLE) && is_div && !bus.annul;
  assign abs_a      = (div_signed && a[WIDTH-1]) ? -a : a;
  assign abs_b      = (div_signed && b[WIDTH-1]) ? -b : b;

  // One restoring-division step: shift the next dividend bit into the partial remainder
  always_comb begin
    rem_sh  = {rem, dvd[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, dvs};
    ge      = (rem_sh >= {1'b0, dvs});
    rem_nx  = ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    q_nx    = {dvd[WIDTH-2:0], ge};
    q_fix   = neg_q ? -q_nx : q_nx;
    r_fix   = neg_r ? -rem_nx : rem_nx;
  end

  // Divider sequencer: IDLE -> BUSY (WIDTH steps) -> DONE, or IDLE -> DONE on divide by zero
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      res_q <= '0;
      res_r <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (b == '0) begin
              res_q <= {WIDTH{1'b1}};
              res_r <= a;
              state <= S_DONE;
            end else begin
              dvd   <= abs_a;
              dvs   <= abs_b;
              rem   <= '0;
              neg_q <= div_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r <= div_signed && a[WIDTH-1];
              cnt   <= CW'(WIDTH);
              state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (bus.annul) begin
            state <= S_IDLE;
          end else begin
            dvd <= q_nx;
            rem <= rem_nx;
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              res_q <= q_fix;
              res_r <= r_fix;
              state <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Result mux for GPR and HI/LO writes plus the stall request; all forced low in reset
  always_comb begin
    bus.out_addr   = {RADDR{1'b0}};
    bus.out_data   = '0;
    bus.out_en     = 1'b0;
    bus.hilo_wr_en = 1'b0;
    bus.hi_data    = '0;
    bus.lo_data    = '0;
    bus.stall_req  = 1'b0;
    if (reset) begin
      bus.out_addr = bus.wr_addr;
      bus.out_en   = bus.wr_en;
      case (bus.alu_sel)
        SEL_LOGIC: case (bus.alu_op)
          OP_OR:   bus.out_data = a | b;
          OP_AND:  bus.out_data = a & b;
          OP_XOR:  bus.out_data = a ^ b;
          OP_NOR:  bus.out_data = ~(a | b);
          default: bus.out_data = '0;
        endcase
        SEL_SHIFT: case (bus.alu_op)
          OP_SRL:  bus.out_data = b >> shamt;
          OP_SRA:  bus.out_data = $signed(b) >>> shamt;
          OP_SLL:  bus.out_data = b << shamt;
          default: bus.out_data = '0;
        endcase
        SEL_MOVE: case (bus.alu_op)
          OP_MOVZ, OP_MOVN: bus.out_data = a;
          OP_MFHI: bus.out_data = eff_hi;
          OP_MFLO: bus.out_data = eff_lo;
          default: bus.out_data = '0;
        endcase
        SEL_ARITH: case (bus.alu_op)
          OP_ADD, OP_ADDU: bus.out_data = sum;
          OP_SUB, OP_SUBU: bus.out_data = diff;
          OP_SLT:  bus.out_data = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
          OP_SLTU: bus.out_data = {{(WIDTH-1){1'b0}}, a < b};
          default: bus.out_data = '0;
        endcase
        default: bus.out_data = '0;
      endcase
      if (bus.alu_sel == SEL_ARITH &&
          ((bus.alu_op == OP_ADD && add_ov) || (bus.alu_op == OP_SUB && sub_ov))) begin
        bus.out_en   = 1'b0;
        bus.out_data = '0;
      end
      case (bus.alu_op)
        OP_MTHI:  begin bus.hilo_wr_en = 1'b1; bus.hi_data = a; bus.lo_data = eff_lo; end
        OP_MTLO:  begin bus.hilo_wr_en = 1'b1; bus.hi_data = eff_hi; bus.lo_data = a; end
        OP_MULT:  begin bus.hilo_wr_en = 1'b1; {bus.hi_data, bus.lo_data} = prod_s; end
        OP_MULTU: begin bus.hilo_wr_en = 1'b1; {bus.hi_data, bus.lo_data} = prod_u; end
        default:  ;
      endcase
      case (state)
        S_IDLE: bus.stall_req = accept;
        S_BUSY: bus.stall_req = !bus.annul;
        S_DONE: if (!bus.annul) begin
          bus.hilo_wr_en = 1'b1;
          bus.hi_data    = res_r;
          bus.lo_data    = res_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
Parametrised execute stage that succeeds the single-cycle EX block. It keeps logic, shift, move and HI/LO-move operations and adds add/sub/compare, a single-cycle multiply and an iterative signed/unsigned divider. The divider raises a pipeline stall request while it runs. The block sits between the ID/EX and EX/MEM pipeline registers, with HI/LO forwarding from the MEM and WB stages.

Parameters:
WIDTH, 32, datapath width (even, >=8); shift amount is src_data1[$clog2(WIDTH)-1:0]
RADDR, 5, register address width

Ports:
clk  in  1  clock, all state changes on rising edge
reset  in  1  synchronous, active-low reset
alu_sel  in  3  result class: 001 logic, 010 shift, 011 move, 100 arith
alu_op  in  8  operation code (values below)
src_data1, src_data2  in  WIDTH  operands (rs, rt)
wr_addr  in  RADDR  destination register
wr_en  in  1  destination write enable
annul  in  1  flush: cancel any in-flight divide
hi_in, lo_in  in  WIDTH  architectural HI/LO
mem_hilo_wr_en, mem_hi, mem_lo  in  1/WIDTH/WIDTH  MEM-stage HI/LO write (forward)
wb_hilo_wr_en, wb_hi, wb_lo  in  1/WIDTH/WIDTH  WB-stage HI/LO write (forward)
out_addr  out  RADDR  passes wr_addr through
out_data  out  WIDTH  GPR result
out_en  out  1  GPR write enable
hilo_wr_en  out  1  HI/LO write enable
hi_data, lo_data  out  WIDTH  HI/LO write data
stall_req  out  1  hold the pipeline while high

Behaviour:
- While reset=0: every output is 0 and the divider is in IDLE. Reset mid-divide aborts the divide with no HI/LO write.
- Opcodes: OR 25h, AND 24h, XOR 26h, NOR 27h; SRL 02h, SRA 03h, SLL 7Ch; MOVZ 0Ah, MOVN 0Bh, MFHI 10h, MTHI 11h, MFLO 12h, MTLO 13h.
- More opcodes: ADD 20h, ADDU 21h, SUB 22h, SUBU 23h, SLT 2Ah, SLTU 2Bh; MULT 18h, MULTU 19h, DIV 1Ah, DIVU 1Bh. Any other code gives a zero result for its class.
- Effective HI/LO, in priority order: mem_* if mem_hilo_wr_en; else wb_* if wb_hilo_wr_en; else hi_in/lo_in.
- Combinational ops (everything except DIV/DIVU) have zero latency; outputs follow the inputs in the same cycle.
- out_addr = wr_addr and out_en = wr_en, with one exception: ADD or SUB signed overflow forces out_en=0 and out_data=0. ADDU/SUBU wrap.
- SRA is an arithmetic shift.
- SLT/SLTU give 1 or 0, zero-extended. Signed compare for SLT, unsigned for SLTU.
- alu_sel outside the listed classes gives out_data=0.
- MTHI: hilo_wr_en=1, hi_data=src_data1, lo_data=effective LO.
- MTLO: hilo_wr_en=1, lo_data=src_data1, hi_data=effective HI.
- MULT/MULTU: full 2*WIDTH product in one cycle, signed or unsigned. hilo_wr_en=1, {hi_data,lo_data}=product.
- When no HI/LO op is active: hilo_wr_en=0 and hi_data=lo_data=0.
- Divider FSM has three states: IDLE, BUSY, DONE.
- IDLE: accepts DIV/DIVU when annul=0. stall_req=1 combinationally in that cycle. Latches |operands| (signed) or raw operands (unsigned) and the sign flags. Sets counter=WIDTH and goes to BUSY.
- Divide-by-zero special case: src_data2==0 goes straight to DONE with quotient={WIDTH{1}}, remainder=src_data1.
- BUSY: one restoring-division step per cycle; counter decrements; stall_req=1. When counter reaches 0, goes to DONE.
- DONE: stall_req=0, hilo_wr_en=1, lo_data=quotient, hi_data=remainder. Next state is always IDLE.
- DONE does not restart on the still-present DIV opcode. The pipeline advances at the end of DONE.
- Sign fix-up for DIV: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
- Most-negative / -1 yields quotient = most-negative and remainder = 0.
- Divide latency: stall_req is high for WIDTH+1 cycles (accept cycle plus WIDTH BUSY cycles); the result appears in cycle T+WIDTH+1.
- annul=1 in BUSY or DONE: stall_req=0 and hilo_wr_en=0 in that cycle; IDLE on the next edge.
- annul=1 in IDLE blocks acceptance of a divide.
- Back-to-back divides: a DIV presented in the cycle after DONE is accepted normally from IDLE.

Test Plan:
- WIDTH=32, OR 0x0000F0F0 | 0x00000F0F -> out_data=0x0000FFFF, out_en=wr_en, same cycle. SRA src2=0x80000000, shift 4 -> 0xF8000000.
- ADD 0x7FFFFFFF + 1 -> out_en=0, out_data=0. ADDU of the same operands -> 0x80000000 with out_en=1.
- MULT 0xFFFFFFFE * 3 -> hilo_wr_en=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MFHI with mem_hilo_wr_en=1, mem_hi=0x1234 and wb_hi=0x5678 -> out_data=0x1234.
- DIVU 100/7 -> stall_req high 33 cycles, then one cycle with lo=14, hi=2, hilo_wr_en=1. DIV 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 5/0 -> DONE after one stall cycle with lo=0xFFFFFFFF, hi=5.
- annul at BUSY cycle 10 -> stall_req=0 immediately, no hilo_wr_en.
- reset=0 mid-divide -> all outputs 0 and IDLE on the next edge.
